qf_reg_bus_if: RTL

//  APB3 slave front-end for the FCB register file. Decodes bus accesses into
//  one-hot write strobes and write data for an array of qf_rw register cells.

---
 rtl/qf_reg_bus_pkg.sv | 16 +
 rtl/qf_reg_addr_dec.sv | 44 ++++
 rtl/qf_reg_bus_if.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/qf_reg_bus_pkg.sv
// Shared definitions for the FCB register-bus front-end.
//   qf_state_e : transfer FSM states (IDLE -> WAIT -> DONE -> IDLE)
//   ADDR_LSB   : first address bit of the word index (byte addresses, 32-bit words)
//   CNT_W      : width of the wait-state counter (WAIT_CYCLES up to 15)
package qf_reg_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } qf_state_e;

  localparam int ADDR_LSB = 2;
  localparam int CNT_W    = 4;

endpackage

// File: rtl/qf_reg_addr_dec.sv
// Combinational address decoder for the register bus.
//   addr_i   : captured byte address
//   write_i  : captured transfer direction (1 = write)
//   idx_o    : word index, addr_i[ADDR_W-1:ADDR_LSB]
//   valid_o  : index in range and address word-aligned
//   err_o    : invalid address, or write to a read-only register
//   onehot_o : one-hot select of the addressed register, zero when invalid
module qf_reg_addr_dec
  import qf_reg_bus_pkg::*;
#(
  parameter int                  NUM_REGS = 8,
  parameter int                  ADDR_W   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic                       write_i,
  output logic [ADDR_W-ADDR_LSB-1:0] idx_o,
  output logic                       valid_o,
  output logic                       err_o,
  output logic [NUM_REGS-1:0]        onehot_o
);

  localparam int IDX_W = ADDR_W - ADDR_LSB;

  logic ro_hit;

  assign idx_o = addr_i[ADDR_W-1:ADDR_LSB];

  always_comb begin
    onehot_o = '0;
    ro_hit   = 1'b0;
    valid_o  = (int'(idx_o) < NUM_REGS) && (addr_i[ADDR_LSB-1:0] == '0);
    // Only a valid address may select a cell, which keeps the strobe at
    // most one-hot and the read-only lookup inside RO_MASK.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (valid_o && (idx_o == IDX_W'(i))) begin
        onehot_o[i] = 1'b1;
        ro_hit      = RO_MASK[i];
      end
    end
    err_o = !valid_o | (write_i & ro_hit);
  end

endmodule

// File: rtl/qf_reg_bus_if.sv
// APB3 slave front-end for the FCB register file.
//   sys_clk, sys_rst_n : clock (rising edge), asynchronous active-low reset
//   psel, penable, pwrite, paddr, pwdata : APB request
//   prdata, pready, pslverr              : APB response (valid while pready=1)
//   reg_wr_en   : one-hot write strobe to register cell i
//   reg_wrdata  : write data to all cells (captured pwdata)
//   reg_rddata  : concatenated cell outputs, cell i at [i*DATA_W +: DATA_W]
//   dbg_state_o : current transfer FSM state
//
// Handshake: a transfer starts when psel=1 and penable=0 are seen in IDLE
// (setup phase). The master then holds psel=1, penable=1 and the request
// stable until pready=1, which lasts exactly one cycle; prdata and pslverr
// are only meaningful in that cycle. Dropping psel before pready aborts the
// transfer without a response or a write strobe.
module qf_reg_bus_if
  import qf_reg_bus_pkg::*;
#(
  parameter int                  NUM_REGS    = 8,
  parameter int                  DATA_W      = 10,
  parameter int                  ADDR_W      = 8,
  parameter int                  WAIT_CYCLES = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS-1:0]          reg_wr_en,
  output logic [DATA_W-1:0]            reg_wrdata,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_rddata,
  output qf_state_e                    dbg_state_o
);

  localparam int IDX_W = ADDR_W - ADDR_LSB;

  qf_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  write_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     prdata_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rd_sel;

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_valid;
  logic                  dec_err;
  logic [NUM_REGS-1:0]   dec_onehot;

  logic                  setup;
  logic                  enter_done;
  logic                  in_done;

  assign setup = psel & ~penable;

  qf_reg_addr_dec #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .RO_MASK  (RO_MASK)
  ) u_dec (
    .addr_i   (addr_q),
    .write_i  (write_q),
    .idx_o    (dec_idx),
    .valid_o  (dec_valid),
    .err_o    (dec_err),
    .onehot_o (dec_onehot)
  );

  // FSM state register and wait counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end
      ST_WAIT: begin
        // Losing psel mid-transfer is a protocol violation: drop it silently.
        if (!psel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        // A setup overlapping DONE is not taken; the master must hold it
        // into the following IDLE cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_done = (state_q == ST_WAIT) && (state_d == ST_DONE);
  assign in_done    = (state_q == ST_DONE);

  // Request capture; reg_wrdata follows wdata_q so it is stable from setup
  // until the next setup.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if ((state_q == ST_IDLE) && setup) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
    end
  end

  // Read mux over the cell array, selected by the captured index.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dec_valid && (dec_idx == IDX_W'(i))) begin
        rd_sel = reg_rddata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Response registered on DONE entry. A write in DONE updates its cell at
  // the DONE edge, so a later read samples the new value here.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else if (enter_done) begin
      prdata_q <= (!write_q && !dec_err) ? rd_sel : '0;
      err_q    <= dec_err;
    end
  end

  assign prdata      = prdata_q;
  assign pready      = in_done;
  assign pslverr     = in_done & err_q;
  assign reg_wr_en   = (in_done && write_q && !err_q) ? dec_onehot : '0;
  assign reg_wrdata  = wdata_q;
  assign dbg_state_o = state_q;

endmodule
